pipelined_opcode_decoder: RTL and testbench

//  Registered, parametrised-depth successor to the combinational opcode decoder in the ID stage.

---
 rtl/pipelined_opcode_decoder.sv | 181 ++++++++++++++++++
 tb/tb_pipelined_opcode_decoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_opcode_decoder.sv
// RV32I opcode/funct decoder with a PIPE_DEPTH-stage registered control bundle, valid/stall/flush
// and a saturating illegal-instruction counter. Define OPDEC_MEXT_EN to accept M-extension R-type ops.
module pipelined_opcode_decoder #(
  parameter int PIPE_DEPTH    = 2,
  parameter int ILLEGAL_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     out_valid,
  output logic                     RegWrite,
  output logic [2:0]               ImmSrc,
  output logic                     PCAdderSrc,
  output logic                     ALUSrcA,
  output logic                     ALUSrcB,
  output logic                     MemWrite,
  output logic [1:0]               ResultSrc,
  output logic                     Branch,
  output logic                     Jump,
  output logic [1:0]               ALUOp,
  output logic                     illegal,
  output logic [ILLEGAL_CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       pc_adder_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic  valid;
    logic  illegal;
    ctrl_t ctrl;
  } stage_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Field order: reg_write_imm_src_pc_adder_src_alu_src_a_alu_src_b_mem_write_result_src_branch_jump_alu_op
  localparam ctrl_t CTRL_LOAD   = 14'b1_000_0_0_1_0_01_0_0_00;
  localparam ctrl_t CTRL_IMM    = 14'b1_000_0_0_1_0_00_0_0_10;
  localparam ctrl_t CTRL_AUIPC  = 14'b1_100_0_1_1_0_00_0_0_00;
  localparam ctrl_t CTRL_STORE  = 14'b0_001_0_0_1_1_00_0_0_00;
  localparam ctrl_t CTRL_REG    = 14'b1_000_0_0_0_0_00_0_0_10;
  localparam ctrl_t CTRL_LUI    = 14'b1_100_0_0_0_0_11_0_0_00;
  localparam ctrl_t CTRL_BRANCH = 14'b0_010_0_0_0_0_00_1_0_01;
  localparam ctrl_t CTRL_JALR   = 14'b1_000_1_0_0_0_10_0_1_00;
  localparam ctrl_t CTRL_JAL    = 14'b1_011_0_0_0_0_10_0_1_00;
`ifdef OPDEC_MEXT_EN
  localparam ctrl_t CTRL_MUL    = 14'b1_000_0_0_0_0_00_0_0_11;
`endif

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_fields;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  // Register specifiers and immediates are not needed to build the control bundle.
  assign unused_instr_fields = ^{in_instr[24:15], in_instr[11:7]};

  ctrl_t dec_ctrl;
  logic  dec_illegal;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned
  // (which would infer a latch); the all-zero default is also the illegal-instruction bundle.
  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_LOAD:   dec_ctrl = CTRL_LOAD;
      OP_IMM:    dec_ctrl = CTRL_IMM;
      OP_AUIPC:  dec_ctrl = CTRL_AUIPC;
      OP_STORE:  dec_ctrl = CTRL_STORE;
      OP_LUI:    dec_ctrl = CTRL_LUI;
      OP_BRANCH: dec_ctrl = CTRL_BRANCH;
      OP_JAL:    dec_ctrl = CTRL_JAL;
      OP_REG: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec_ctrl = CTRL_REG;
        end
`ifdef OPDEC_MEXT_EN
        else if (funct7 == 7'b0000001) begin
          dec_ctrl = CTRL_MUL;
        end
`endif
        else begin
          dec_illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          dec_ctrl = CTRL_JALR;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default:   dec_illegal = 1'b1;
    endcase
  end

  stage_t stage_in;
  stage_t pipe_q [PIPE_DEPTH];

  always_comb begin
    stage_in         = '0;
    stage_in.valid   = in_valid;
    stage_in.illegal = dec_illegal;
    stage_in.ctrl    = dec_ctrl;
  end

  // NOTE: only the valid bits are reset; the payload is don't-care while invalid because the
  // outputs are gated by valid, so the wide datapath registers need no reset fan-out.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        pipe_q[k].valid <= 1'b0;
      end
    end else if (!stall) begin
      pipe_q[0] <= stage_in;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  stage_t out_stage;
  ctrl_t  out_ctrl;

  always_comb begin
    out_stage = pipe_q[PIPE_DEPTH-1];
    out_ctrl  = out_stage.valid ? out_stage.ctrl : '0;
  end

  assign out_valid  = out_stage.valid;
  assign illegal    = out_stage.valid & out_stage.illegal;
  assign RegWrite   = out_ctrl.reg_write;
  assign ImmSrc     = out_ctrl.imm_src;
  assign PCAdderSrc = out_ctrl.pc_adder_src;
  assign ALUSrcA    = out_ctrl.alu_src_a;
  assign ALUSrcB    = out_ctrl.alu_src_b;
  assign MemWrite   = out_ctrl.mem_write;
  assign ResultSrc  = out_ctrl.result_src;
  assign Branch     = out_ctrl.branch;
  assign Jump       = out_ctrl.jump;
  assign ALUOp      = out_ctrl.alu_op;

  // An illegal instruction is counted as it leaves the output stage, i.e. on a retiring edge.
  logic [ILLEGAL_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!flush && !stall && illegal && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ILLEGAL_CNT_W'(1);
    end
  end

  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_pipelined_opcode_decoder.sv
// Directed self-checking bench for pipelined_opcode_decoder: depth-2, depth-2 with a 2-bit
// counter, and depth-4 instances share one stimulus stream.
module tb_pipelined_opcode_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        stall;
  logic        flush;

  // {out_valid, illegal, RegWrite, ImmSrc, PCAdderSrc, ALUSrcA, ALUSrcB, MemWrite, ResultSrc, Branch, Jump, ALUOp}
  wire [15:0] ctl2, ctlc, ctl4;
  wire [7:0]  cnt2, cnt4;
  wire [1:0]  cntc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_opcode_decoder #(.PIPE_DEPTH(2), .ILLEGAL_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .stall(stall), .flush(flush),
    .out_valid(ctl2[15]), .illegal(ctl2[14]), .RegWrite(ctl2[13]), .ImmSrc(ctl2[12:10]),
    .PCAdderSrc(ctl2[9]), .ALUSrcA(ctl2[8]), .ALUSrcB(ctl2[7]), .MemWrite(ctl2[6]),
    .ResultSrc(ctl2[5:4]), .Branch(ctl2[3]), .Jump(ctl2[2]), .ALUOp(ctl2[1:0]), .illegal_count(cnt2));

  pipelined_opcode_decoder #(.PIPE_DEPTH(2), .ILLEGAL_CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .stall(stall), .flush(flush),
    .out_valid(ctlc[15]), .illegal(ctlc[14]), .RegWrite(ctlc[13]), .ImmSrc(ctlc[12:10]),
    .PCAdderSrc(ctlc[9]), .ALUSrcA(ctlc[8]), .ALUSrcB(ctlc[7]), .MemWrite(ctlc[6]),
    .ResultSrc(ctlc[5:4]), .Branch(ctlc[3]), .Jump(ctlc[2]), .ALUOp(ctlc[1:0]), .illegal_count(cntc));

  pipelined_opcode_decoder #(.PIPE_DEPTH(4), .ILLEGAL_CNT_W(8)) dut_d4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .stall(stall), .flush(flush),
    .out_valid(ctl4[15]), .illegal(ctl4[14]), .RegWrite(ctl4[13]), .ImmSrc(ctl4[12:10]),
    .PCAdderSrc(ctl4[9]), .ALUSrcA(ctl4[8]), .ALUSrcB(ctl4[7]), .MemWrite(ctl4[6]),
    .ResultSrc(ctl4[5:4]), .Branch(ctl4[3]), .Jump(ctl4[2]), .ALUOp(ctl4[1:0]), .illegal_count(cnt4));

  // Hand-encoded expected outputs: {out_valid, illegal, bundle}.
  localparam logic [15:0] E_NONE   = 16'h0000;
  localparam logic [15:0] E_ILL    = {2'b11, 14'b0};
  localparam logic [15:0] E_LOAD   = {2'b10, 14'b1_000_0_0_1_0_01_0_0_00};
  localparam logic [15:0] E_ADDI   = {2'b10, 14'b1_000_0_0_1_0_00_0_0_10};
  localparam logic [15:0] E_AUIPC  = {2'b10, 14'b1_100_0_1_1_0_00_0_0_00};
  localparam logic [15:0] E_SW     = {2'b10, 14'b0_001_0_0_1_1_00_0_0_00};
  localparam logic [15:0] E_ADD    = {2'b10, 14'b1_000_0_0_0_0_00_0_0_10};
  localparam logic [15:0] E_LUI    = {2'b10, 14'b1_100_0_0_0_0_11_0_0_00};
  localparam logic [15:0] E_BEQ    = {2'b10, 14'b0_010_0_0_0_0_00_1_0_01};
  localparam logic [15:0] E_JALR   = {2'b10, 14'b1_000_1_0_0_0_10_0_1_00};
  localparam logic [15:0] E_JAL    = {2'b10, 14'b1_011_0_0_0_0_10_0_1_00};
  localparam logic [15:0] E_MUL    = {2'b10, 14'b1_000_0_0_0_0_00_0_0_11};

  localparam logic [31:0] I_ADDI = 32'h00A00093;
  localparam logic [31:0] I_SW   = 32'h00112023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_MUL  = 32'h02208033;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr);
    in_valid = v;
    in_instr = instr;
  endtask

  task automatic apply_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (ctl2 !== E_NONE || ctl4 !== E_NONE || ctlc !== E_NONE) begin
      failures++;
      $display("FAIL reset_outputs: got %h/%h/%h expected %h", ctl2, ctl4, ctlc, E_NONE);
    end
    checks++;
    if (cnt2 !== 8'd0 || cnt4 !== 8'd0 || cntc !== 2'd0) begin
      failures++;
      $display("FAIL reset_count: got %0d/%0d/%0d expected 0", cnt2, cnt4, cntc);
    end
  endtask

  // Back-to-back stream through the depth-2 instance: instruction i appears after step i+1.
  task automatic test_decode_back_to_back();
    logic [31:0] instrs [13];
    logic [15:0] exps   [13];
    instrs = '{I_ADDI, I_SW, I_BEQ, I_LW, 32'h123450B7, 32'h00001097, 32'h008000EF, 32'h000080E7,
               32'h002081B3, 32'h402081B3, 32'h000090E7, 32'h042081B3, I_BAD};
    exps   = '{E_ADDI, E_SW, E_BEQ, E_LOAD, E_LUI, E_AUIPC, E_JAL, E_JALR,
               E_ADD, E_ADD, E_ILL, E_ILL, E_ILL};
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      if (i < 13) drive(1'b1, instrs[i]);
      else        drive(1'b0, 32'h0);
      step();
      if (i == 0) begin
        checks++;
        if (ctl2[15] !== 1'b0) begin
          failures++;
          $display("FAIL latency_early: out_valid got %b expected 0", ctl2[15]);
        end
      end else if (i <= 13) begin
        checks++;
        if (ctl2 !== exps[i-1]) begin
          failures++;
          $display("FAIL decode[%0d]: got %h expected %h", i - 1, ctl2, exps[i-1]);
        end
      end
    end
    checks++;
    if (cnt2 !== 8'd3) begin
      failures++;
      $display("FAIL decode_illegal_count: got %0d expected 3", cnt2);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(1'b1, I_BAD);
      else       drive(1'b0, 32'h0);
      step();
      if (i >= 1 && i <= 5) begin
        checks++;
        if (ctlc !== E_ILL) begin
          failures++;
          $display("FAIL sat_bundle[%0d]: got %h expected %h", i, ctlc, E_ILL);
        end
      end
      if (i >= 2) begin
        checks++;
        if (cntc !== ((i - 1 > 3) ? 2'd3 : 2'(i - 1))) begin
          failures++;
          $display("FAIL sat_count[%0d]: got %0d expected %0d", i, cntc, (i - 1 > 3) ? 3 : i - 1);
        end
      end
    end
    checks++;
    if (cnt2 !== 8'd5) begin
      failures++;
      $display("FAIL wide_count: got %0d expected 5", cnt2);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    drive(1'b1, I_BAD);  step();
    drive(1'b1, I_ADDI); step();
    stall = 1'b1;
    drive(1'b1, I_SW);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ctl2 !== E_ILL || cnt2 !== 8'd0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got %h cnt %0d expected %h cnt 0", i, ctl2, cnt2, E_ILL);
      end
    end
    stall = 1'b0;
    drive(1'b0, 32'h0);
    step();
    checks++;
    if (ctl2 !== E_ADDI || cnt2 !== 8'd1) begin
      failures++;
      $display("FAIL stall_release: got %h cnt %0d expected %h cnt 1", ctl2, cnt2, E_ADDI);
    end
    step();
    checks++;
    if (ctl2 !== E_NONE || cnt2 !== 8'd1) begin
      failures++;
      $display("FAIL stall_dropped_input: got %h cnt %0d expected %h cnt 1", ctl2, cnt2, E_NONE);
    end
  endtask

  task automatic test_flush_with_stall();
    apply_reset();
    drive(1'b1, I_BAD);  step();
    drive(1'b1, I_ADDI); step();
    checks++;
    if (ctl2 !== E_ILL) begin
      failures++;
      $display("FAIL flush_pre: got %h expected %h", ctl2, E_ILL);
    end
    flush = 1'b1; stall = 1'b1;
    drive(1'b1, I_SW);
    step();
    checks++;
    if (ctl2 !== E_NONE || cnt2 !== 8'd0) begin
      failures++;
      $display("FAIL flush_stall: got %h cnt %0d expected %h cnt 0", ctl2, cnt2, E_NONE);
    end
    flush = 1'b0; stall = 1'b0;
    drive(1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (ctl2 !== E_NONE || cnt2 !== 8'd0) begin
        failures++;
        $display("FAIL flush_drain[%0d]: got %h cnt %0d expected %h cnt 0", i, ctl2, cnt2, E_NONE);
      end
    end
  endtask

  task automatic test_depth4_flush();
    apply_reset();
    drive(1'b1, I_ADDI); step();
    drive(1'b0, 32'h0);  step(); step();
    checks++;
    if (ctl4[15] !== 1'b0) begin
      failures++;
      $display("FAIL d4_latency_early: out_valid got %b expected 0", ctl4[15]);
    end
    step();
    checks++;
    if (ctl4 !== E_ADDI) begin
      failures++;
      $display("FAIL d4_latency: got %h expected %h", ctl4, E_ADDI);
    end
    drive(1'b1, I_LW);  step();
    drive(1'b1, I_SW);  step();
    drive(1'b1, I_BEQ); step();
    flush = 1'b1;
    drive(1'b1, 32'h008000EF);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ctl4 !== E_NONE) begin
        failures++;
        $display("FAIL d4_flush[%0d]: got %h expected %h", i, ctl4, E_NONE);
      end
      step();
    end
  endtask

  task automatic test_mext();
    apply_reset();
    drive(1'b1, I_MUL); step();
    drive(1'b0, 32'h0); step();
    checks++;
`ifdef OPDEC_MEXT_EN
    if (ctl2 !== E_MUL) begin
      failures++;
      $display("FAIL mext_decode: got %h expected %h", ctl2, E_MUL);
    end
`else
    if (ctl2 !== E_ILL) begin
      failures++;
      $display("FAIL mext_decode: got %h expected %h", ctl2, E_ILL);
    end
`endif
    step();
    checks++;
`ifdef OPDEC_MEXT_EN
    if (cnt2 !== 8'd0) begin
      failures++;
      $display("FAIL mext_count: got %0d expected 0", cnt2);
    end
`else
    if (cnt2 !== 8'd1) begin
      failures++;
      $display("FAIL mext_count: got %0d expected 1", cnt2);
    end
`endif
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    drive(1'b1, I_BAD);  step();
    drive(1'b1, I_BAD);  step();
    drive(1'b1, I_ADDI); step();
    drive(1'b1, I_ADDI); step();
    checks++;
    if (ctl2 !== E_ADDI || cnt2 !== 8'd2) begin
      failures++;
      $display("FAIL midreset_pre: got %h cnt %0d expected %h cnt 2", ctl2, cnt2, E_ADDI);
    end
    reset = 1'b1;
    drive(1'b1, I_BAD);
    step();
    checks++;
    if (ctl2 !== E_NONE || cnt2 !== 8'd0) begin
      failures++;
      $display("FAIL midreset: got %h cnt %0d expected %h cnt 0", ctl2, cnt2, E_NONE);
    end
    reset = 1'b0;
    drive(1'b0, 32'h0);
    step();
    checks++;
    if (ctl2 !== E_NONE || cnt2 !== 8'd0) begin
      failures++;
      $display("FAIL midreset_after: got %h cnt %0d expected %h cnt 0", ctl2, cnt2, E_NONE);
    end
  endtask

  initial begin
    test_reset();
    test_decode_back_to_back();
    test_saturate();
    test_stall();
    test_flush_with_stall();
    test_depth4_flush();
    test_mext();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
